mux_serializer_ctrl: RTL and testbench

//   Parallel-to-serial controller that sits directly upstream of mux_8x1.
//   - Accepts one 8-bit word over a valid/ready handshake and holds it on mux_in.
//   - Steps mux_sel through all 8 positions, one step per accepted bit.
//   - Reads the selected bit back on mux_y and presents it as a serial stream

---
 rtl/mux_serializer_ctrl_if.sv | 28 ++
 rtl/mux_serializer_ctrl.sv | 131 +++++++++++++
 tb/tb_mux_serializer_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_serializer_ctrl_if.sv
// mux_serializer_ctrl_if
// Groups the parallel input handshake, the mux_8x1 drive/return lines and the
// serial output handshake of mux_serializer_ctrl into a single bundle.
// master: the serializer controller itself.
// slave : the surroundings (word source, mux_8x1, serial sink).
interface mux_serializer_ctrl_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] mux_in;
  logic [2:0] mux_sel;
  logic       mux_y;
  logic       ser_data;
  logic       ser_valid;
  logic       ser_ready;
  logic       ser_last;
  logic       busy;

  modport master (
    input  in_data, in_valid, mux_y, ser_ready,
    output in_ready, mux_in, mux_sel, ser_data, ser_valid, ser_last, busy
  );

  modport slave (
    output in_data, in_valid, mux_y, ser_ready,
    input  in_ready, mux_in, mux_sel, ser_data, ser_valid, ser_last, busy
  );
endinterface

// File: rtl/mux_serializer_ctrl.sv
// mux_serializer_ctrl
// Parallel-to-serial controller placed in front of a mux_8x1. A word is
// captured into a holding register that drives the mux data inputs, then the
// select is stepped one position per accepted serial beat while the mux output
// is fed straight back out as the serial bit.
// Optional feature macro: PARITY_EN adds a ninth beat carrying the even
// parity of the held word, and moves ser_last onto that beat.
module mux_serializer_ctrl #(
  parameter bit MSB_FIRST  = 1'b0,
  parameter int GAP_CYCLES = 0
) (
  input logic                   clk,
  input logic                   rst,
  mux_serializer_ctrl_if.master bus
);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

  localparam logic [2:0] FIRST_SEL = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] FINAL_SEL = MSB_FIRST ? 3'd0 : 3'd7;
  // Last value of the gap counter before returning to IDLE; unused when the gap is disabled.
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);
  localparam state_t AFTER_DATA = (GAP_CYCLES > 0) ? GAP : IDLE;
`ifdef PARITY_EN
  localparam state_t AFTER_SHIFT = PAR;
`else
  localparam state_t AFTER_SHIFT = AFTER_DATA;
`endif

  state_t     r_state;
  logic [7:0] r_muxIn;
  logic [2:0] r_muxSel;
  logic [3:0] r_gapCnt;

  state_t     w_nextState;
  logic [7:0] w_nextMuxIn;
  logic [2:0] w_nextMuxSel;
  logic [3:0] w_nextGapCnt;
  logic       w_inReady;
  logic       w_serValid;
  logic       w_serData;
  logic       w_serLast;

  // State, holding word, select index and gap counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_muxIn  <= 8'h00;
      r_muxSel <= 3'd0;
      r_gapCnt <= 4'd0;
    end else begin
      r_state  <= w_nextState;
      r_muxIn  <= w_nextMuxIn;
      r_muxSel <= w_nextMuxSel;
      r_gapCnt <= w_nextGapCnt;
    end
  end

  // Next-state and handshake outputs; the select only moves on a completed serial beat.
  always_comb begin
    w_nextState  = r_state;
    w_nextMuxIn  = r_muxIn;
    w_nextMuxSel = r_muxSel;
    w_nextGapCnt = r_gapCnt;
    w_inReady    = 1'b0;
    w_serValid   = 1'b0;
    w_serData    = 1'b0;
    w_serLast    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_inReady = 1'b1;
        if (bus.in_valid) begin
          w_nextMuxIn  = bus.in_data;
          w_nextMuxSel = FIRST_SEL;
          w_nextState  = SHIFT;
        end
      end
      SHIFT: begin
        w_serValid = 1'b1;
        w_serData  = bus.mux_y;
`ifndef PARITY_EN
        w_serLast  = (r_muxSel == FINAL_SEL);
`endif
        if (bus.ser_ready) begin
          if (r_muxSel == FINAL_SEL) begin
            w_nextState  = AFTER_SHIFT;
            w_nextGapCnt = 4'd0;
          end else if (MSB_FIRST) begin
            w_nextMuxSel = r_muxSel - 3'd1;
          end else begin
            w_nextMuxSel = r_muxSel + 3'd1;
          end
        end
      end
`ifdef PARITY_EN
      PAR: begin
        w_serValid = 1'b1;
        w_serLast  = 1'b1;
        w_serData  = ^r_muxIn;
        if (bus.ser_ready) begin
          w_nextState  = AFTER_DATA;
          w_nextGapCnt = 4'd0;
        end
      end
`endif
      GAP: begin
        if (r_gapCnt == GAP_LAST) begin
          w_nextState = IDLE;
        end else begin
          w_nextGapCnt = r_gapCnt + 4'd1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = w_inReady;
  assign bus.mux_in    = r_muxIn;
  assign bus.mux_sel   = r_muxSel;
  assign bus.ser_data  = w_serData;
  assign bus.ser_valid = w_serValid;
  assign bus.ser_last  = w_serLast;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mux_serializer_ctrl.sv
// tb_mux_serializer_ctrl
// Directed bench for mux_serializer_ctrl. Two instances are exercised:
// dutA (LSB first, no gap) and dutB (MSB first, three gap cycles). A behavioural
// mux_8x1 closes the mux_in/mux_sel -> mux_y loop for each instance.
// Parity scenarios are compiled in when PARITY_EN is defined.
module tb_mux_serializer_ctrl;

`ifdef PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mux_serializer_ctrl_if ifA();
  mux_serializer_ctrl_if ifB();

  assign ifA.mux_y = ifA.mux_in[ifA.mux_sel];
  assign ifB.mux_y = ifB.mux_in[ifB.mux_sel];

  mux_serializer_ctrl #(.MSB_FIRST(1'b0), .GAP_CYCLES(0)) dutA (
    .clk(clk), .rst(rst), .bus(ifA)
  );

  mux_serializer_ctrl #(.MSB_FIRST(1'b1), .GAP_CYCLES(3)) dutB (
    .clk(clk), .rst(rst), .bus(ifB)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    logic [7:0] got;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    got = {ifA.in_ready, ifA.ser_valid, ifA.busy, ifA.ser_last, 1'b0, ifA.mux_sel};
    total++;
    if (got !== 8'b1000_0000) begin
      bad++;
      $display("[TB] FAIL reset_ctrl_A got=%b want=%b", got, 8'b1000_0000);
    end
    total++;
    if (ifA.mux_in !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_muxin_A got=%h want=00", ifA.mux_in);
    end
    got = {ifB.in_ready, ifB.ser_valid, ifB.busy, ifB.ser_last, 1'b0, ifB.mux_sel};
    total++;
    if (got !== 8'b1000_0000) begin
      bad++;
      $display("[TB] FAIL reset_ctrl_B got=%b want=%b", got, 8'b1000_0000);
    end
    total++;
    if (ifB.mux_in !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_muxin_B got=%h want=00", ifB.mux_in);
    end
  endtask

  task automatic test_lsb_stream();
    logic [7:0] word;
    logic [7:0] got;
    logic [7:0] want;
    word = 8'hA5;
    @(negedge clk);
    total++;
    if (ifA.in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL a5_ready_before got=%b want=1", ifA.in_ready);
    end
    ifA.in_data   = word;
    ifA.in_valid  = 1'b1;
    ifA.ser_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ifA.in_valid = 1'b0;
      ifA.in_data  = 8'h00;
      got  = {ifA.ser_valid, ifA.ser_data, ifA.ser_last, ifA.busy, ifA.in_ready, ifA.mux_sel};
      want = {1'b1, word[k], (k == 7) && !PAR_ON, 1'b1, 1'b0, 3'(k)};
      total++;
      if (got !== want) begin
        bad++;
        $display("[TB] FAIL a5_bit%0d got=%b want=%b", k, got, want);
      end
    end
    total++;
    if (ifA.mux_in !== word) begin
      bad++;
      $display("[TB] FAIL a5_muxin_hold got=%h want=%h", ifA.mux_in, word);
    end
`ifdef PARITY_EN
    @(negedge clk);
    got  = {5'b0, ifA.ser_valid, ifA.ser_data, ifA.ser_last};
    want = {5'b0, 1'b1, 1'b0, 1'b1};
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL a5_parity got=%b want=%b", got, want);
    end
`endif
    @(negedge clk);
    got = {5'b0, ifA.in_ready, ifA.ser_valid, ifA.busy};
    total++;
    if (got !== 8'b0000_0100) begin
      bad++;
      $display("[TB] FAIL a5_idle_after got=%b want=%b", got, 8'b0000_0100);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] word;
    logic [7:0] got;
    logic [7:0] want;
    word = 8'h3C;
    @(negedge clk);
    ifA.in_data   = word;
    ifA.in_valid  = 1'b1;
    ifA.ser_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ifA.in_valid = 1'b0;
      ifA.in_data  = 8'hFF;
      got  = {ifA.ser_valid, ifA.ser_data, ifA.ser_last, 2'b00, ifA.mux_sel};
      want = {1'b1, word[k], (k == 7) && !PAR_ON, 2'b00, 3'(k)};
      total++;
      if (got !== want) begin
        bad++;
        $display("[TB] FAIL 3c_bit%0d got=%b want=%b", k, got, want);
      end
      if (k == 2) begin
        ifA.ser_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          got  = {ifA.ser_valid, ifA.ser_data, 3'b000, ifA.mux_sel};
          want = {1'b1, 1'b1, 3'b000, 3'd2};
          total++;
          if (got !== want) begin
            bad++;
            $display("[TB] FAIL 3c_stall%0d got=%b want=%b", s, got, want);
          end
        end
        ifA.ser_ready = 1'b1;
      end
    end
    total++;
    if (ifA.mux_in !== word) begin
      bad++;
      $display("[TB] FAIL 3c_muxin_hold got=%h want=%h", ifA.mux_in, word);
    end
`ifdef PARITY_EN
    @(negedge clk);
    total++;
    if ({ifA.ser_valid, ifA.ser_data, ifA.ser_last} !== 3'b101) begin
      bad++;
      $display("[TB] FAIL 3c_parity got=%b want=101", {ifA.ser_valid, ifA.ser_data, ifA.ser_last});
    end
`endif
    @(negedge clk);
    total++;
    if (ifA.in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL 3c_idle_after got=%b want=1", ifA.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [2];
    logic [7:0] word;
    logic [7:0] got;
    logic [7:0] want;
    words[0] = 8'h81;
    words[1] = 8'h7E;
    @(negedge clk);
    ifB.in_data   = words[0];
    ifB.in_valid  = 1'b1;
    ifB.ser_ready = 1'b1;
    for (int w = 0; w < 2; w++) begin
      word = words[w];
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (k == 0) begin
          if (w == 0) ifB.in_data = words[1];
          else        ifB.in_valid = 1'b0;
        end
        got  = {ifB.ser_valid, ifB.ser_data, ifB.ser_last, ifB.busy, ifB.in_ready, ifB.mux_sel};
        want = {1'b1, word[7-k], (k == 7) && !PAR_ON, 1'b1, 1'b0, 3'(7 - k)};
        total++;
        if (got !== want) begin
          bad++;
          $display("[TB] FAIL b2b_w%0d_bit%0d got=%b want=%b", w, k, got, want);
        end
      end
      total++;
      if (ifB.mux_in !== word) begin
        bad++;
        $display("[TB] FAIL b2b_w%0d_muxin got=%h want=%h", w, ifB.mux_in, word);
      end
`ifdef PARITY_EN
      @(negedge clk);
      total++;
      if ({ifB.ser_valid, ifB.ser_data, ifB.ser_last} !== 3'b101) begin
        bad++;
        $display("[TB] FAIL b2b_w%0d_parity got=%b want=101", w, {ifB.ser_valid, ifB.ser_data, ifB.ser_last});
      end
`endif
      for (int g = 0; g < 3; g++) begin
        @(negedge clk);
        got = {5'b0, ifB.ser_valid, ifB.in_ready, ifB.busy};
        total++;
        if (got !== 8'b0000_0001) begin
          bad++;
          $display("[TB] FAIL b2b_w%0d_gap%0d got=%b want=%b", w, g, got, 8'b0000_0001);
        end
      end
      @(negedge clk);
      got = {5'b0, ifB.ser_valid, ifB.in_ready, ifB.busy};
      total++;
      if (got !== 8'b0000_0010) begin
        bad++;
        $display("[TB] FAIL b2b_w%0d_idle got=%b want=%b", w, got, 8'b0000_0010);
      end
    end
  endtask

  task automatic test_reset_midword();
    logic [7:0] got;
    @(negedge clk);
    ifA.in_data   = 8'hFF;
    ifA.in_valid  = 1'b1;
    ifA.ser_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ifA.in_valid = 1'b0;
    end
    total++;
    if ({ifA.ser_valid, ifA.mux_sel} !== 4'b1100) begin
      bad++;
      $display("[TB] FAIL ff_at_bit4 got=%b want=1100", {ifA.ser_valid, ifA.mux_sel});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    got = {3'b0, ifA.ser_valid, ifA.in_ready, ifA.busy, ifA.ser_last, ifA.mux_sel == 3'd0};
    total++;
    if (got !== 8'b0000_1001) begin
      bad++;
      $display("[TB] FAIL ff_reset_ctrl got=%b want=%b", got, 8'b0000_1001);
    end
    total++;
    if (ifA.mux_in !== 8'h00) begin
      bad++;
      $display("[TB] FAIL ff_reset_muxin got=%h want=00", ifA.mux_in);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (ifA.ser_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL ff_no_tail%0d got=%b want=0", c, ifA.ser_valid);
      end
    end
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    logic [7:0] words [2];
    logic       parities [2];
    logic [7:0] got;
    logic [7:0] want;
    words[0] = 8'h07;
    parities[0] = 1'b1;
    words[1] = 8'h03;
    parities[1] = 1'b0;
    ifA.ser_ready = 1'b1;
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      ifA.in_data  = words[w];
      ifA.in_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        ifA.in_valid = 1'b0;
        got  = {5'b0, ifA.ser_valid, ifA.ser_data, ifA.ser_last};
        want = {5'b0, 1'b1, words[w][k], 1'b0};
        total++;
        if (got !== want) begin
          bad++;
          $display("[TB] FAIL par_w%0d_bit%0d got=%b want=%b", w, k, got, want);
        end
      end
      @(negedge clk);
      got  = {5'b0, ifA.ser_valid, ifA.ser_data, ifA.ser_last};
      want = {5'b0, 1'b1, parities[w], 1'b1};
      total++;
      if (got !== want) begin
        bad++;
        $display("[TB] FAIL par_w%0d_beat got=%b want=%b", w, got, want);
      end
      @(negedge clk);
      total++;
      if (ifA.in_ready !== 1'b1) begin
        bad++;
        $display("[TB] FAIL par_w%0d_idle got=%b want=1", w, ifA.in_ready);
      end
    end
  endtask
`endif

  // Runs every scenario in order and prints the summary.
  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    ifA.in_data   = 8'h00;
    ifA.in_valid  = 1'b0;
    ifA.ser_ready = 1'b1;
    ifB.in_data   = 8'h00;
    ifB.in_valid  = 1'b0;
    ifB.ser_ready = 1'b1;
    test_reset();
    test_lsb_stream();
    test_backpressure();
    test_back_to_back();
    test_reset_midword();
`ifdef PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
